// File: rtl/bfp_pkg.sv
// Shared definitions for the block-floating-point datapath: default widths,
// encoder state encoding and the leading-one helper.
package bfp_pkg;

   localparam int DEF_IN_WIDTH      = 16;
   localparam int DEF_FRACTION_SIZE = 11;
   localparam int DEF_EXP_SIZE      = 5;
   localparam int DEF_BLOCK_SIZE    = 8;
   localparam int EXP_MAX           = DEF_IN_WIDTH - DEF_FRACTION_SIZE;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      CALC  = 2'd1,
      DRAIN = 2'd2
   } bfp_state_t;

   // Index of the highest set bit, -1 when no bit is set.
   function automatic int msb_index(input logic [31:0] acc);
      int idx;
      idx = -1;
      for (int i = 0; i < 32; i++) begin
         if (acc[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/bfp_leading_one.sv
// Combinational priority encoder: position of the most significant set bit
// of a magnitude word, plus an all-zero flag. Supports W up to 31.
module bfp_leading_one
   import bfp_pkg::*;
#(
   parameter int W  = 16,
   parameter int PW = $clog2(W) + 2
) (
   input  logic [W-1:0]          acc,
   output logic signed [PW-1:0]  p,
   output logic                  zero
);

   always_comb begin
      p    = PW'(msb_index(32'(acc)));
      zero = (acc == '0);
   end

endmodule

// File: rtl/bfp_block_encoder.sv
// Buffers one block of signed samples, derives a shared exponent from the
// OR of their one's-complement magnitudes, then drains the scaled fractions.
module bfp_block_encoder
   import bfp_pkg::*;
#(
   parameter int InWidth      = DEF_IN_WIDTH,
   parameter int FractionSize = DEF_FRACTION_SIZE,
   parameter int ExpSize      = DEF_EXP_SIZE,
   parameter int BlockSize    = DEF_BLOCK_SIZE
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [InWidth-1:0]       in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [FractionSize-1:0]  out_fraction,
   output logic [ExpSize-1:0]       out_exp,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_last
);

   localparam int CW = $clog2(BlockSize);
   localparam int PW = $clog2(InWidth) + 2;
   localparam logic [CW-1:0] LAST = CW'(BlockSize - 1);

   bfp_state_t state, state_nxt;

   logic [CW-1:0]              cnt, cnt_nxt, cnt_inc;
   logic [InWidth-1:0]         acc, acc_nxt, mag;
   logic signed [InWidth-1:0]  buffer [BlockSize];
   logic signed [PW-1:0]       lo_p;
   logic                       lo_zero;
   int                         need;
   logic [ExpSize-1:0]         exp_calc;
   logic                       in_xfer, out_xfer;

   logic                       in_ready_nxt, out_valid_nxt, out_last_nxt;
   logic [FractionSize-1:0]    out_fraction_nxt;
   logic [ExpSize-1:0]         out_exp_nxt;

   // Arithmetic shift then keep the low FractionSize bits; the exponent
   // choice guarantees the discarded upper bits are pure sign extension.
   function automatic logic [FractionSize-1:0] frac_shift(
      input logic signed [InWidth-1:0] s,
      input logic [ExpSize-1:0]        e
   );
      return FractionSize'(s >>> e);
   endfunction

   bfp_leading_one #(.W(InWidth), .PW(PW)) u_leading_one (
      .acc  (acc),
      .p    (lo_p),
      .zero (lo_zero)
   );

   assign in_xfer  = in_valid & in_ready & (state == FILL);
   assign out_xfer = out_valid & out_ready;
   assign mag      = in_data ^ {InWidth{in_data[InWidth-1]}};
   assign cnt_inc  = cnt + CW'(1);

   // Sign bit plus magnitude bits must fit the fraction; the excess is the exponent.
   always_comb begin
      need     = int'(lo_p) + 2;
      exp_calc = '0;
      if (!lo_zero && need > FractionSize) exp_calc = ExpSize'(need - FractionSize);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= FILL;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         FILL:    if (in_xfer && cnt == LAST)  state_nxt = CALC;
         CALC:                                 state_nxt = DRAIN;
         DRAIN:   if (out_xfer && cnt == LAST) state_nxt = FILL;
         default:                              state_nxt = FILL;
      endcase
   end

   always_comb begin
      cnt_nxt          = cnt;
      acc_nxt          = acc;
      out_valid_nxt    = out_valid;
      out_last_nxt     = out_last;
      out_fraction_nxt = out_fraction;
      out_exp_nxt      = out_exp;
      case (state)
         FILL: begin
            if (in_xfer) begin
               acc_nxt = acc | mag;
               cnt_nxt = (cnt == LAST) ? '0 : cnt_inc;
            end
         end
         CALC: begin
            cnt_nxt          = '0;
            out_exp_nxt      = exp_calc;
            out_fraction_nxt = frac_shift(buffer[0], exp_calc);
            out_valid_nxt    = 1'b1;
            out_last_nxt     = 1'b0;
         end
         DRAIN: begin
            if (out_xfer) begin
               if (cnt == LAST) begin
                  cnt_nxt          = '0;
                  acc_nxt          = '0;
                  out_valid_nxt    = 1'b0;
                  out_last_nxt     = 1'b0;
                  out_fraction_nxt = '0;
                  out_exp_nxt      = '0;
               end else begin
                  cnt_nxt          = cnt_inc;
                  out_fraction_nxt = frac_shift(buffer[cnt_inc], out_exp);
                  out_last_nxt     = (cnt_inc == LAST);
               end
            end
         end
         default: ;
      endcase
      in_ready_nxt = (state_nxt == FILL);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt          <= '0;
         acc          <= '0;
         in_ready     <= 1'b1;
         out_valid    <= 1'b0;
         out_last     <= 1'b0;
         out_fraction <= '0;
         out_exp      <= '0;
      end else begin
         cnt          <= cnt_nxt;
         acc          <= acc_nxt;
         in_ready     <= in_ready_nxt;
         out_valid    <= out_valid_nxt;
         out_last     <= out_last_nxt;
         out_fraction <= out_fraction_nxt;
         out_exp      <= out_exp_nxt;
      end
   end

   // Sample storage carries no reset; cnt decides which entries are live.
   always_ff @(posedge clk) begin
      if (in_xfer) buffer[cnt] <= $signed(in_data);
   end

endmodule
